// File: rtl/sad_search_ctrl_pkg.sv
// sad_search_ctrl_pkg: shared defaults and FSM encoding for the motion-search controller
package sad_search_ctrl_pkg;
  localparam int SEARCH_RANGE_DEF = 8;
  localparam int SAD_W_DEF = 32;
  localparam int MV_W_DEF = 5;
  // Width of the SAD result bus shared with the SAD engine
  localparam int SAD_ENGINE_W = SAD_W_DEF;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_UPDATE, S_NEXT, S_FIN} state_e;
endpackage

// File: rtl/sad_cand_counter.sv
// sad_cand_counter: 2-D raster displacement counter, x inner, both axes -P..P-1
module sad_cand_counter import sad_search_ctrl_pkg::*; #(
  parameter int P = SEARCH_RANGE_DEF,
  parameter int MV_W = MV_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   step_i,
  output logic signed [MV_W-1:0] x_o,
  output logic signed [MV_W-1:0] y_o,
  output logic                   last_o
);
  localparam logic signed [MV_W-1:0] LO = MV_W'(-P);
  localparam logic signed [MV_W-1:0] HI = MV_W'(P - 1);
  localparam logic signed [MV_W-1:0] ONE = MV_W'(1);
  logic signed [MV_W-1:0] x_q, x_d, y_q, y_d;
  logic x_end;
  always_comb begin
    x_end = x_q == HI;
    x_d = clr_i ? LO : step_i ? (x_end ? LO : x_q + ONE) : x_q;
    y_d = clr_i ? LO : (step_i && x_end) ? y_q + ONE : y_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= LO;
      y_q <= LO;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end
  assign x_o = x_q;
  assign y_o = y_q;
  assign last_o = x_end && y_q == HI;
endmodule

// File: rtl/sad_search_ctrl.sv
// sad_search_ctrl: full-search block-matching controller tracking the minimum-SAD displacement
module sad_search_ctrl import sad_search_ctrl_pkg::*; #(
  parameter int SEARCH_RANGE = SEARCH_RANGE_DEF,
  parameter int SAD_W = SAD_ENGINE_W,
  parameter int MV_W = MV_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   sad_go,
  input  logic [SAD_W-1:0]       sad_val,
  input  logic                   sad_done,
  output logic signed [MV_W-1:0] cand_x,
  output logic signed [MV_W-1:0] cand_y,
  output logic [SAD_W-1:0]       best_sad,
  output logic signed [MV_W-1:0] best_x,
  output logic signed [MV_W-1:0] best_y,
  output logic                   busy,
  output logic                   done
);
  state_e state_q;
  logic go_q, busy_q, done_q, first_q, last, better;
  logic [SAD_W-1:0] sad_q, best_sad_q;
  logic signed [MV_W-1:0] best_x_q, best_y_q;
  sad_cand_counter #(.P(SEARCH_RANGE), .MV_W(MV_W)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q == S_IDLE && start),
    .step_i (state_q == S_NEXT && !last),
    .x_o    (cand_x),
    .y_o    (cand_y),
    .last_o (last)
  );
  // Strict compare keeps the earlier candidate on ties
  assign better = first_q || sad_q < best_sad_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      go_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      first_q <= 1'b0;
      sad_q <= '0;
      best_sad_q <= '1;
      best_x_q <= '0;
      best_y_q <= '0;
    end else begin
      go_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          state_q <= S_ISSUE;
          go_q <= 1'b1;
          busy_q <= 1'b1;
          first_q <= 1'b1;
        end
        S_ISSUE: state_q <= S_WAIT;
        S_WAIT: if (sad_done) begin
          sad_q <= sad_val;
          state_q <= S_UPDATE;
        end
        S_UPDATE: begin
          if (better) begin
            best_sad_q <= sad_q;
            best_x_q <= cand_x;
            best_y_q <= cand_y;
          end
          first_q <= 1'b0;
          state_q <= S_NEXT;
        end
        S_NEXT: begin
          state_q <= last ? S_FIN : S_ISSUE;
          go_q <= !last;
          done_q <= last;
        end
        S_FIN: begin
          state_q <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign sad_go = go_q;
  assign busy = busy_q;
  assign done = done_q;
  assign best_sad = best_sad_q;
  assign best_x = best_x_q;
  assign best_y = best_y_q;
endmodule

// File: doc/sad_search_ctrl.md
SAD_SEARCH_CTRL -- requirements
Module: sad_search_ctrl

Interface
REQ-001 Parameter: SEARCH_RANGE, default 8, half-width P of the search window; candidate displacement per axis runs -P..+P-1, giving (2P)^2 candidates.
REQ-002 Parameter: SAD_W, default 32, width of SAD values.
REQ-003 Parameter: MV_W, default 5, signed width of displacement outputs; must hold -P..+P-1.
REQ-004 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port: rst  in  1  asynchronous, active-high reset.
REQ-006 Port: start  in  1  request a full search; sampled in IDLE only.
REQ-007 Port: sad_go  out  1  one-cycle pulse that starts the SAD engine for the current candidate.
REQ-008 Port: sad_val  in  SAD_W  SAD result of the current candidate.
REQ-009 Port: sad_done  in  1  one-cycle pulse, sad_val valid in the same cycle.
REQ-010 Port: cand_x, cand_y  out  MV_W signed  current candidate displacement, consumed by the pixel fetch/address logic.
REQ-011 Port: best_sad  out  SAD_W  minimum SAD found so far.
REQ-012 Port: best_x, best_y  out  MV_W signed  displacement of best_sad.
REQ-013 Port: busy  out  1  high in every state except IDLE.
REQ-014 Port: done  out  1  one-cycle pulse when the search completes.

Function
REQ-015 States: IDLE, ISSUE, WAIT, UPDATE, NEXT, FIN; outputs are Moore-decoded from state and registers.
REQ-016 IDLE: start=1 -> cand_x=cand_y=-P, first flag set, go to ISSUE; otherwise stay.
REQ-017 ISSUE: sad_go=1 for exactly one cycle, then WAIT; cand_x/cand_y stable from ISSUE through NEXT.
REQ-018 WAIT: stay until sad_done=1, register sad_val, go to UPDATE; no timeout.
REQ-019 UPDATE: if first flag or registered SAD < best_sad (strict, unsigned), load best_sad/best_x/best_y from it and the current candidate; clear first flag; go to NEXT.
REQ-020 Ties keep the earlier candidate; scan order is raster: cand_x inner (-P..P-1), cand_y outer.
REQ-021 NEXT: cand_x=P-1 and cand_y=P-1 -> FIN; cand_x=P-1 -> cand_x=-P, cand_y+1, ISSUE; else cand_x+1, ISSUE.
REQ-022 FIN: done=1 for one cycle, go to IDLE; best_* hold until the next accepted start.
REQ-023 best_* are not cleared at start; they change only in UPDATE (first candidate overwrites unconditionally).
REQ-024 start while busy is ignored; sad_done outside WAIT is ignored.
REQ-025 Per-candidate cost: 3 cycles + SAD engine latency (ISSUE, UPDATE, NEXT).
REQ-026 Displacement counters do not wrap within a search; arithmetic is MV_W-bit signed.

Reset
REQ-027 rst=1 forces IDLE asynchronously, mid-search included; the in-flight SAD result is discarded.
REQ-028 Reset values: sad_go=0, busy=0, done=0, cand_x=cand_y=-P, best_sad=all-ones, best_x=best_y=0, first flag=0.

Structure
REQ-029 A shared package/include holds the state encoding, SEARCH_RANGE/SAD_W/MV_W defaults, and the SAD width shared with the SAD engine.
REQ-030 One sub-module, sad_cand_counter, holds the 2-D raster counter (clear to -P, step, last flag); the comparator stays in the top module.

Verification (P=2, 16 candidates; SAD model answers 4 cycles after sad_go)
REQ-031 Model SAD=10*(|x-1|+|y+1|), start -> done after 16 sad_go pulses, best_sad=0, best=(1,-1).
REQ-032 Model SAD=100 constant -> best_sad=100, best=(-2,-2) (first in raster order wins ties).
REQ-033 Model SAD=0xFFFFFFFF everywhere -> best_sad=0xFFFFFFFF, best=(-2,-2) (first candidate loaded unconditionally).
REQ-034 start pulsed during WAIT of candidate 5 plus a spurious sad_done in UPDATE -> no extra sad_go, still exactly 16 sad_go and one done.
REQ-035 rst asserted during WAIT of candidate 7 -> next edge busy=0, sad_go=0, best_sad=0xFFFFFFFF; new start runs a clean 16-candidate search.
REQ-036 Min at last candidate (SAD=5 at (1,1), 50 elsewhere) -> best=(1,1), done exactly one cycle after its UPDATE-NEXT sequence.
